// File: rtl/if_id_pipe_reg.sv
// IF/ID stage register with a valid/ready handshake. Carries PC, IR and a
// sideband field from fetch to decode. An optional skid entry lets in_ready
// come straight from a flop. Flush empties the stage and zeroes its data so
// that IR=0, a MIPS nop, is what decode sees. Two saturating counters track
// stall cycles and flush cycles.
module if_id_pipe_reg #(
   parameter int PC_BITS  = 32,
   parameter int IR_BITS  = 32,
   parameter int SB_BITS  = 8,
   parameter int SKID_EN  = 1,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [PC_BITS-1:0]  PC_in,
   input  logic [IR_BITS-1:0]  IR_in,
   input  logic [SB_BITS-1:0]  SB_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PC_BITS-1:0]  PC_out,
   output logic [IR_BITS-1:0]  IR_out,
   output logic [SB_BITS-1:0]  SB_out,
   output logic [1:0]          occupancy,
   output logic [CNT_BITS-1:0] stall_cnt,
   output logic [CNT_BITS-1:0] flush_cnt
);

   logic                r_out_valid;
   logic [PC_BITS-1:0]  r_pc;
   logic [IR_BITS-1:0]  r_ir;
   logic [SB_BITS-1:0]  r_sb;
   logic [CNT_BITS-1:0] r_stall_cnt;
   logic [CNT_BITS-1:0] r_flush_cnt;

   logic                w_in_ready;
   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_skid_valid;
   logic [PC_BITS-1:0]  w_skid_pc;
   logic [IR_BITS-1:0]  w_skid_ir;
   logic [SB_BITS-1:0]  w_skid_sb;
   logic                w_take_skid;
   logic                w_take_in;
   logic                w_out_valid_nxt;

   assign w_in_fire  = in_valid & w_in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   generate
      if (SKID_EN != 0) begin : g_skid
         logic               r_skid_valid;
         logic               r_in_ready;
         logic [PC_BITS-1:0] r_skid_pc;
         logic [IR_BITS-1:0] r_skid_ir;
         logic [SB_BITS-1:0] r_skid_sb;
         logic               w_load_skid;
         logic               w_skid_valid_nxt;

         // Skid captures input only when the output entry is stalled.
         always_comb begin
            w_load_skid      = w_in_fire & r_out_valid & ~out_ready;
            w_skid_valid_nxt = r_skid_valid;
            if (r_skid_valid & w_out_fire) begin
               w_skid_valid_nxt = 1'b0;
            end else if (w_load_skid) begin
               w_skid_valid_nxt = 1'b1;
            end
         end

         // Skid entry storage; in_ready is kept as the flopped inverse of skid_valid.
         always_ff @(posedge clk) begin
            if (rst || flush) begin
               r_skid_valid <= 1'b0;
               r_in_ready   <= 1'b1;
               r_skid_pc    <= '0;
               r_skid_ir    <= '0;
               r_skid_sb    <= '0;
            end else begin
               r_skid_valid <= w_skid_valid_nxt;
               r_in_ready   <= ~w_skid_valid_nxt;
               if (w_load_skid) begin
                  r_skid_pc <= PC_in;
                  r_skid_ir <= IR_in;
                  r_skid_sb <= SB_in;
               end
            end
         end

         assign w_in_ready   = r_in_ready;
         assign w_skid_valid = r_skid_valid;
         assign w_skid_pc    = r_skid_pc;
         assign w_skid_ir    = r_skid_ir;
         assign w_skid_sb    = r_skid_sb;
      end else begin : g_noskid
         assign w_in_ready   = ~r_out_valid | out_ready;
         assign w_skid_valid = 1'b0;
         assign w_skid_pc    = '0;
         assign w_skid_ir    = '0;
         assign w_skid_sb    = '0;
      end
   endgenerate

   // Choose what the output entry holds next; a waiting skid entry always goes first.
   always_comb begin
      w_take_skid     = w_skid_valid & w_out_fire;
      w_take_in       = w_in_fire & (~r_out_valid | out_ready);
      w_out_valid_nxt = r_out_valid;
      if (w_take_skid || w_take_in) begin
         w_out_valid_nxt = 1'b1;
      end else if (w_out_fire) begin
         w_out_valid_nxt = 1'b0;
      end
   end

   // Output entry; the data registers change only on a load, so a stalled word stays bit-exact.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_out_valid <= 1'b0;
         r_pc        <= '0;
         r_ir        <= '0;
         r_sb        <= '0;
      end else begin
         r_out_valid <= w_out_valid_nxt;
         if (w_take_skid) begin
            r_pc <= w_skid_pc;
            r_ir <= w_skid_ir;
            r_sb <= w_skid_sb;
         end else if (w_take_in) begin
            r_pc <= PC_in;
            r_ir <= IR_in;
            r_sb <= SB_in;
         end
      end
   end

   // Saturating stall and flush counters; flush does not clear them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
         end
         if (flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_BITS'(1);
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign PC_out    = r_pc;
   assign IR_out    = r_ir;
   assign SB_out    = r_sb;
   assign occupancy = {1'b0, r_out_valid} + {1'b0, w_skid_valid};
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg. Instance a has the skid buffer and
// 4-bit counters; instance b is built without the skid buffer.
module tb_if_id_pipe_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // instance a: SKID_EN=1, CNT_BITS=4
   logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_pc_in, a_ir_in, a_pc_out, a_ir_out;
   logic [7:0]  a_sb_in, a_sb_out;
   logic [1:0]  a_occ;
   logic [3:0]  a_stall, a_flushc;

   // instance b: SKID_EN=0, CNT_BITS=16
   logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_pc_in, b_ir_in, b_pc_out, b_ir_out;
   logic [7:0]  b_sb_in, b_sb_out;
   logic [1:0]  b_occ;
   logic [15:0] b_stall, b_flushc;

   if_id_pipe_reg #(.PC_BITS(32), .IR_BITS(32), .SB_BITS(8), .SKID_EN(1), .CNT_BITS(4)) u_a (
      .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .PC_in(a_pc_in), .IR_in(a_ir_in), .SB_in(a_sb_in), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .PC_out(a_pc_out), .IR_out(a_ir_out), .SB_out(a_sb_out),
      .occupancy(a_occ), .stall_cnt(a_stall), .flush_cnt(a_flushc));

   if_id_pipe_reg #(.PC_BITS(32), .IR_BITS(32), .SB_BITS(8), .SKID_EN(0), .CNT_BITS(16)) u_b (
      .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .PC_in(b_pc_in), .IR_in(b_ir_in), .SB_in(b_sb_in), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .PC_out(b_pc_out), .IR_out(b_ir_out), .SB_out(b_sb_out),
      .occupancy(b_occ), .stall_cnt(b_stall), .flush_cnt(b_flushc));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      a_pc_in = '0; a_ir_in = '0; a_sb_in = '0;
      b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
      b_pc_in = '0; b_ir_in = '0; b_sb_in = '0;
      #1;
      tick;

      // reset state
      chk("a_rst_out_valid", 64'(a_out_valid), 64'd0);
      chk("a_rst_pc", 64'(a_pc_out), 64'd0);
      chk("a_rst_ir", 64'(a_ir_out), 64'd0);
      chk("a_rst_sb", 64'(a_sb_out), 64'd0);
      chk("a_rst_occ", 64'(a_occ), 64'd0);
      chk("a_rst_stall", 64'(a_stall), 64'd0);
      chk("a_rst_flushc", 64'(a_flushc), 64'd0);
      chk("a_rst_in_ready", 64'(a_in_ready), 64'd1);

      // streaming, one word per cycle
      a_rst = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         a_pc_in = 32'h0040_0000 + 32'(4 * k);
         a_ir_in = 32'(k);
         a_sb_in = 8'(k);
         tick;
         chk("stream_valid", 64'(a_out_valid), 64'd1);
         chk("stream_pc", 64'(a_pc_out), 64'h0040_0000 + 64'(4 * k));
         chk("stream_ir", 64'(a_ir_out), 64'(k));
         chk("stream_sb", 64'(a_sb_out), 64'(k));
         chk("stream_in_ready", 64'(a_in_ready), 64'd1);
      end
      a_in_valid = 1'b0;
      tick;
      chk("drain_valid", 64'(a_out_valid), 64'd0);
      chk("drain_pc_hold", 64'(a_pc_out), 64'h0040_0020);
      chk("stream_stall", 64'(a_stall), 64'd0);

      // skid fill and ordered drain
      a_in_valid = 1'b1; a_pc_in = 32'h0040_0004; a_ir_in = 32'h11; a_out_ready = 1'b0;
      tick;
      chk("skid_out_pc", 64'(a_pc_out), 64'h0040_0004);
      chk("skid_occ1", 64'(a_occ), 64'd1);
      a_pc_in = 32'h0040_0008; a_ir_in = 32'h22;
      tick;
      chk("skid_occ2", 64'(a_occ), 64'd2);
      chk("skid_in_ready", 64'(a_in_ready), 64'd0);
      chk("skid_hold_pc", 64'(a_pc_out), 64'h0040_0004);
      chk("skid_stall1", 64'(a_stall), 64'd1);
      a_in_valid = 1'b0;
      tick;
      chk("skid_stall2", 64'(a_stall), 64'd2);
      chk("skid_hold_ir", 64'(a_ir_out), 64'h11);
      a_out_ready = 1'b1;
      tick;
      chk("skid_drain_pc", 64'(a_pc_out), 64'h0040_0008);
      chk("skid_drain_ir", 64'(a_ir_out), 64'h22);
      chk("skid_drain_occ", 64'(a_occ), 64'd1);
      chk("skid_drain_in_ready", 64'(a_in_ready), 64'd1);
      tick;
      chk("skid_empty_valid", 64'(a_out_valid), 64'd0);
      chk("skid_stall_final", 64'(a_stall), 64'd2);

      // flush with full stage and concurrent input
      a_in_valid = 1'b1; a_pc_in = 32'h0040_0100; a_out_ready = 1'b0;
      tick;
      a_pc_in = 32'h0040_0104;
      tick;
      chk("pre_flush_occ", 64'(a_occ), 64'd2);
      a_flush = 1'b1; a_pc_in = 32'h0040_0200; a_ir_in = 32'h8C01_0000;
      tick;
      chk("flush_valid", 64'(a_out_valid), 64'd0);
      chk("flush_ir", 64'(a_ir_out), 64'd0);
      chk("flush_pc", 64'(a_pc_out), 64'd0);
      chk("flush_occ", 64'(a_occ), 64'd0);
      chk("flush_cnt1", 64'(a_flushc), 64'd1);
      chk("flush_stall", 64'(a_stall), 64'd4);
      chk("flush_in_ready", 64'(a_in_ready), 64'd1);
      // flush while in_ready=1: the firing input is dropped
      tick;
      chk("flush_fire_valid", 64'(a_out_valid), 64'd0);
      chk("flush_cnt2", 64'(a_flushc), 64'd2);
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      tick;
      chk("post_flush_valid", 64'(a_out_valid), 64'd0);
      chk("post_flush_ir", 64'(a_ir_out), 64'd0);

      // stall counter saturation
      a_in_valid = 1'b1; a_pc_in = 32'h0040_0300; a_out_ready = 1'b0;
      tick;
      a_in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (i == 10) chk("sat_reach", 64'(a_stall), 64'd15);
      end
      chk("sat_hold", 64'(a_stall), 64'd15);
      chk("sat_pc_hold", 64'(a_pc_out), 64'h0040_0300);

      // reset mid-stall with a full stage
      a_in_valid = 1'b1; a_pc_in = 32'h0040_0304;
      tick;
      chk("pre_rst_occ", 64'(a_occ), 64'd2);
      a_rst = 1'b1; a_pc_in = 32'h0040_0308;
      tick;
      chk("rst_mid_valid", 64'(a_out_valid), 64'd0);
      chk("rst_mid_pc", 64'(a_pc_out), 64'd0);
      chk("rst_mid_occ", 64'(a_occ), 64'd0);
      chk("rst_mid_stall", 64'(a_stall), 64'd0);
      chk("rst_mid_flushc", 64'(a_flushc), 64'd0);
      chk("rst_mid_in_ready", 64'(a_in_ready), 64'd1);
      a_rst = 1'b0; a_pc_in = 32'h0040_030C; a_out_ready = 1'b1;
      tick;
      chk("post_rst_valid", 64'(a_out_valid), 64'd1);
      chk("post_rst_pc", 64'(a_pc_out), 64'h0040_030C);
      a_in_valid = 1'b0;

      // no-skid build
      b_rst = 1'b0; b_in_valid = 1'b1; b_pc_in = 32'h0050_0000; b_ir_in = 32'hA; b_out_ready = 1'b0;
      #1;
      chk("b_in_ready_empty", 64'(b_in_ready), 64'd1);
      tick;
      chk("b_load_valid", 64'(b_out_valid), 64'd1);
      chk("b_load_pc", 64'(b_pc_out), 64'h0050_0000);
      chk("b_in_ready_stalled", 64'(b_in_ready), 64'd0);
      b_pc_in = 32'h0050_0004;
      tick;
      chk("b_hold_pc", 64'(b_pc_out), 64'h0050_0000);
      chk("b_occ", 64'(b_occ), 64'd1);
      chk("b_stall", 64'(b_stall), 64'd1);
      b_out_ready = 1'b1; b_pc_in = 32'h0050_0008; b_ir_in = 32'hB;
      #1;
      chk("b_in_ready_comb", 64'(b_in_ready), 64'd1);
      tick;
      chk("b_nobubble_valid", 64'(b_out_valid), 64'd1);
      chk("b_nobubble_pc", 64'(b_pc_out), 64'h0050_0008);
      chk("b_nobubble_ir", 64'(b_ir_out), 64'hB);
      b_in_valid = 1'b0;
      tick;
      chk("b_drain_valid", 64'(b_out_valid), 64'd0);
      chk("b_drain_occ", 64'(b_occ), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
